// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum stream packer: layer operation codes
// and default widths.
package psum_pkg;

    typedef enum logic [1:0] {
        OP_CONV    = 2'd0,
        OP_FC      = 2'd1,
        OP_POOL    = 2'd2,
        OP_ELTWISE = 2'd3
    } op_e;

    localparam int DEF_TDATA_WIDTH = 32;
    localparam int DEF_ELEM_WIDTH  = 1;
    localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/psum_word_fifo.sv
// Output word FIFO with registered head (valid/data) and a live occupancy count.
// A push into an empty FIFO shows up on out_valid one cycle later.
module psum_word_fifo
    import psum_pkg::*;
#(
    parameter int WIDTH = DEF_TDATA_WIDTH + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]    count_next;
    logic             do_push, do_pop, head_from_push;

    assign do_pop  = out_valid && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_comb begin
        count_next = count;
        rd_next    = rd_ptr;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;
        if (do_pop)
            rd_next = rd_ptr + 1'b1;
        // The pushed word becomes the head when nothing else remains in front of it.
        head_from_push = do_push && (do_pop ? (count == CW'(1)) : (count == '0));
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (count_next != '0)
                out_data <= head_from_push ? push_data : mem[rd_next];
        end
    end

endmodule

// File: rtl/psum_stream_packer.sv
// Packs narrow partial-sum elements LSB-first into AXI4-Stream words, flushing
// a (possibly partial) word with tlast on each layer_finish.
module psum_stream_packer
    import psum_pkg::*;
#(
    parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int ELEM_WIDTH  = DEF_ELEM_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             operation,
    input  logic                   layer_finish,
    input  logic                   in_valid,
    input  logic [ELEM_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    output logic                   overflow
);

    localparam int EPW  = TDATA_WIDTH / ELEM_WIDTH;
    localparam int CNTW = $clog2(EPW + 1);
    localparam int OCW  = $clog2(FIFO_DEPTH) + 1;

    if (TDATA_WIDTH % ELEM_WIDTH != 0) begin : g_bad_width
        $error("TDATA_WIDTH must be a multiple of ELEM_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic [TDATA_WIDTH-1:0] acc_q, acc_next;
    logic [CNTW-1:0]        cnt_q, cnt_after;
    logic                   flush_pending_q, overflow_q;
    logic [OCW-1:0]         occ;
    logic                   space, accept, flush_req, do_flush, push;
    logic [TDATA_WIDTH:0]   push_word;

    assign space     = occ < OCW'(FIFO_DEPTH);
    assign in_ready  = space && !flush_pending_q;
    assign accept    = in_valid && in_ready;
    assign flush_req = layer_finish || flush_pending_q;
    assign do_flush  = flush_req && space;
    assign overflow  = overflow_q;

    always_comb begin
        acc_next = acc_q;
        if (accept) begin
            for (int k = 0; k < EPW; k++)
                if (cnt_q == CNTW'(k))
                    acc_next[k*ELEM_WIDTH +: ELEM_WIDTH] = in_data;
        end
        cnt_after = cnt_q + CNTW'(accept);

        push      = 1'b0;
        push_word = '0;
        // A flush absorbs an element accepted in the same cycle, so a word
        // completed by that element goes out once, marked last.
        if (do_flush) begin
            if (cnt_after != '0) begin
                push      = 1'b1;
                push_word = {1'b1, acc_next};
            end else if (operation == OP_CONV) begin
                push      = 1'b1;
                push_word = {1'b1, {TDATA_WIDTH{1'b0}}};
            end
        end else if (accept && cnt_after == CNTW'(EPW)) begin
            push      = 1'b1;
            push_word = {1'b0, acc_next};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q           <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            if (in_valid && !in_ready)
                overflow_q <= 1'b1;
            if (push || do_flush) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                acc_q <= acc_next;
                cnt_q <= cnt_after;
            end
            flush_pending_q <= flush_req && !space;
        end
    end

    psum_word_fifo #(
        .WIDTH (TDATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .out_ready (m_tready),
        .out_valid (m_tvalid),
        .out_data  ({m_tlast, m_tdata}),
        .count     (occ)
    );

endmodule

// File: tb/tb_psum_stream_packer.sv
// Scoreboard bench: stimulus pushes expected beats, per-DUT monitors pop and
// compare on each handshake. One instance with 1-bit elements, one with 4-bit.
module tb_psum_stream_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  op1, op4;
    logic        lf1, lf4, v1, v4, d1, tr1, tr4;
    logic [3:0]  d4;
    logic        ir1, ir4, tv1, tv4, tl1, tl4, ov1, ov4;
    logic [31:0] td1, td4;

    typedef struct packed { logic [31:0] d; logic l; } beat_t;
    beat_t q1[$], q4[$];
    int cmp = 0, err = 0;

    psum_stream_packer #(.TDATA_WIDTH(32), .ELEM_WIDTH(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .operation(op1), .layer_finish(lf1),
        .in_valid(v1), .in_data(d1), .in_ready(ir1), .m_tvalid(tv1),
        .m_tready(tr1), .m_tdata(td1), .m_tlast(tl1), .overflow(ov1));

    psum_stream_packer #(.TDATA_WIDTH(32), .ELEM_WIDTH(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .operation(op4), .layer_finish(lf4),
        .in_valid(v4), .in_data(d4), .in_ready(ir4), .m_tvalid(tv4),
        .m_tready(tr4), .m_tdata(td4), .m_tlast(tl4), .overflow(ov4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step1(input logic v, input logic d, input logic lf);
        v1 = v; d1 = d; lf1 = lf;
        @(posedge clk); #1;
    endtask

    task automatic step4(input logic v, input logic [3:0] d, input logic lf);
        v4 = v; d4 = d; lf4 = lf;
        @(posedge clk); #1;
    endtask

    task automatic exp1(input logic [31:0] d, input logic l);
        beat_t b; b.d = d; b.l = l; q1.push_back(b);
    endtask

    task automatic exp4(input logic [31:0] d, input logic l);
        beat_t b; b.d = d; b.l = l; q4.push_back(b);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (q1.size() != 0 || q4.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("drain_pending_beats", 32'(q1.size() + q4.size()), 32'd0);
    endtask

    // Monitor for the 1-bit-element instance, including hold-while-stalled check.
    initial begin
        logic  stall;
        beat_t held, e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) stall = 1'b0;
            else begin
                if (tv1) begin
                    if (stall) begin
                        chk("stall_hold_data1", td1, held.d);
                        chk("stall_hold_last1", 32'(tl1), 32'(held.l));
                    end
                    if (tr1) begin
                        if (q1.size() == 0) begin
                            cmp++; err++;
                            $display("FAIL unexpected_beat1: got %h last %0d, expected none", td1, tl1);
                        end else begin
                            e = q1.pop_front();
                            chk("beat_data1", td1, e.d);
                            chk("beat_last1", 32'(tl1), 32'(e.l));
                        end
                    end
                end
                stall = tv1 && !tr1;
                held.d = td1; held.l = tl1;
            end
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && tv4 && tr4) begin
                if (q4.size() == 0) begin
                    cmp++; err++;
                    $display("FAIL unexpected_beat4: got %h last %0d, expected none", td4, tl4);
                end else begin
                    e = q4.pop_front();
                    chk("beat_data4", td4, e.d);
                    chk("beat_last4", 32'(tl4), 32'(e.l));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        op1 = 2'd0; op4 = 2'd0; lf1 = 0; lf4 = 0; v1 = 0; v4 = 0; d1 = 0; d4 = 0;
        tr1 = 1'b1; tr4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir1), 32'd1);
        chk("rst_tvalid", 32'(tv1), 32'd0);
        chk("rst_overflow", 32'(ov1), 32'd0);
        chk("rst_tdata", td1, 32'd0);
        chk("rst_tlast", 32'(tl1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full word of alternating 1,0 and its one-cycle output latency.
        exp1(32'h5555_5555, 1'b0);
        for (int k = 0; k < 31; k++) step1(1'b1, ~k[0], 1'b0);
        v1 = 1'b1; d1 = 1'b0;
        @(negedge clk);
        chk("latency_before_push", 32'(tv1), 32'd0);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("latency_after_push", 32'(tv1), 32'd1);
        @(posedge clk); #1;

        // Empty flush: zero word in conv mode, nothing otherwise.
        exp1(32'h0, 1'b1);
        step1(1'b0, 1'b0, 1'b1);
        op1 = 2'd1;
        step1(1'b0, 1'b0, 1'b1);
        repeat (4) step1(1'b0, 1'b0, 1'b0);
        op1 = 2'd0;

        // 32nd element coincides with layer_finish: exactly one last word.
        exp1(32'hFFFF_FFFF, 1'b1);
        for (int k = 0; k < 31; k++) step1(1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1);
        repeat (4) step1(1'b0, 1'b0, 1'b0);
        chk("coincident_single_word", 32'(q1.size()), 32'd0);

        // Back-pressure: fill the FIFO, drop one element, pend a flush, drain.
        tr1 = 1'b0;
        exp1(32'hAAAA_AAAA, 1'b0);
        exp1(32'hCCCC_CCCC, 1'b0);
        exp1(32'hF0F0_F0F0, 1'b0);
        exp1(32'hFF00_FF00, 1'b0);
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 32; k++) step1(1'b1, k[w], 1'b0);
        v1 = 1'b1; d1 = 1'b1;
        @(negedge clk);
        chk("full_in_ready_low", 32'(ir1), 32'd0);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("overflow_set", 32'(ov1), 32'd1);
        @(posedge clk); #1;
        exp1(32'h0, 1'b1);
        step1(1'b0, 1'b0, 1'b1);
        chk("flush_pending_blocks_input", 32'(ir1), 32'd0);
        repeat (3) step1(1'b0, 1'b0, 1'b0);
        tr1 = 1'b1;
        wait_drain();
        chk("in_ready_after_drain", 32'(ir1), 32'd1);
        chk("overflow_sticky", 32'(ov1), 32'd1);

        // 4-bit elements.
        exp4(32'h8765_4321, 1'b0);
        for (int k = 0; k < 8; k++) step4(1'b1, 4'(k + 1), 1'b0);
        exp4(32'h0000_0CBA, 1'b1);
        step4(1'b1, 4'hA, 1'b0);
        step4(1'b1, 4'hB, 1'b0);
        step4(1'b1, 4'hC, 1'b0);
        step4(1'b0, 4'h0, 1'b1);
        exp4(32'h0000_0065, 1'b1);
        step4(1'b1, 4'h5, 1'b0);
        step4(1'b1, 4'h6, 1'b1);
        op4 = 2'd1;
        step4(1'b0, 4'h0, 1'b1);
        op4 = 2'd0;
        exp4(32'h89AB_CDEF, 1'b1);
        for (int k = 0; k < 7; k++) step4(1'b1, 4'(15 - k), 1'b0);
        step4(1'b1, 4'h8, 1'b1);
        step4(1'b0, 4'h0, 1'b0);
        wait_drain();
        chk("ew4_no_overflow", 32'(ov4), 32'd0);

        // Reset mid-word with two words queued: everything is discarded.
        tr1 = 1'b0;
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 32; k++) step1(1'b1, k[w], 1'b0);
        for (int k = 0; k < 5; k++) step1(1'b1, 1'b1, 1'b0);
        v1 = 1'b0;
        chk("queued_before_reset", 32'(tv1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_tvalid_async", 32'(tv1), 32'd0);
        chk("reset_overflow_async", 32'(ov1), 32'd0);
        chk("reset_in_ready_async", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tr1 = 1'b1;
        repeat (10) step1(1'b0, 1'b0, 1'b0);
        chk("no_stale_beats", 32'(tv1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/psum_stream_packer.md
PSUM_STREAM_PACKER -- requirements
Module: psum_stream_packer

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32, output word width in bits.
REQ-002 SHALL have parameter ELEM_WIDTH, default 1, width of one psum element in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of output words buffered.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port operation  in  2  layer mode; 2'd0 = always-terminate mode.
REQ-007 SHALL have port layer_finish  in  1  one-cycle pulse marking end of layer.
REQ-008 SHALL have port in_valid  in  1  element strobe.
REQ-009 SHALL have port in_data  in  ELEM_WIDTH  element value.
REQ-010 SHALL have port in_ready  out  1  element accepted when in_valid && in_ready.
REQ-011 SHALL have ports m_tvalid (out 1), m_tready (in 1), m_tdata (out TDATA_WIDTH), m_tlast (out 1) as AXI4-Stream master.
REQ-012 SHALL have port overflow  out  1  sticky flag, element dropped.

Function
REQ-013 SHALL pack EPW = TDATA_WIDTH/ELEM_WIDTH elements per word, LSB-first: k-th accepted element in bits [k*ELEM_WIDTH +: ELEM_WIDTH].
REQ-014 SHALL clear all accumulator bits at the start of each word; unwritten upper bits of a partial word are zero.
REQ-015 SHALL push the word into the FIFO in the cycle the EPW-th element is accepted, with tlast=0 unless REQ-017 applies.
REQ-016 On layer_finish with elem_count>0, SHALL push the partial word with tlast=1 and reset elem_count to 0.
REQ-017 in_valid accepted in the same cycle as layer_finish SHALL be included in the flushed word; if it completes the word, exactly one word with tlast=1 is pushed.
REQ-018 On layer_finish with elem_count==0: operation==2'd0 SHALL push an all-zero word with tlast=1; other modes SHALL push nothing.
REQ-019 in_ready SHALL be 1 iff FIFO occupancy < FIFO_DEPTH and no flush is pending.
REQ-020 in_valid while in_ready==0 SHALL drop the element, leave state unchanged and set overflow to 1 until reset.
REQ-021 layer_finish while FIFO full SHALL set flush_pending; the flush executes in the first cycle with space, then flush_pending clears.
REQ-022 FIFO SHALL accept push and pop in the same cycle when full; occupancy is unchanged.
REQ-023 m_tvalid SHALL rise one cycle after a push into an empty FIFO (latency 1).
REQ-024 m_tdata/m_tlast SHALL be held stable while m_tvalid && !m_tready; pop occurs only on m_tvalid && m_tready.
REQ-025 Words SHALL leave in push order; none are lost or duplicated.

Reset
REQ-026 rst_n low SHALL asynchronously clear m_tvalid, m_tlast, m_tdata, overflow, elem_count, flush_pending, FIFO pointers and occupancy to 0, and set in_ready to 1.
REQ-027 Reset mid-word or mid-stream SHALL discard the partial word and all buffered words; no output follows deassertion until new input.

Structure
REQ-028 Package psum_pkg SHALL hold operation codes (OP_CONV=2'd0, ...) and default widths.
REQ-029 SHALL elaborate-time check TDATA_WIDTH % ELEM_WIDTH == 0 and FIFO_DEPTH a power of two >= 2.
REQ-030 The buffer SHALL be a sub-module psum_word_fifo, width TDATA_WIDTH+1, with registered outputs.

Verification
REQ-031 EW=1, 32 elems alternating 1,0, m_tready=1 -> one word 0x55555555, tlast=0, m_tvalid one cycle after 32nd element.
REQ-032 EW=4, 3 elems 0xA,0xB,0xC then layer_finish -> word 0x00000CBA, tlast=1.
REQ-033 layer_finish with elem_count==0: operation=0 -> word 0x00000000 tlast=1; operation=1 -> no beat.
REQ-034 EW=1, 32nd element coincident with layer_finish -> exactly one word, tlast=1.
REQ-035 m_tready=0, push 5 words, depth 4 -> in_ready low after 4th, extra element drops, overflow=1; release m_tready -> 4 words in order, data stable while stalled.
REQ-036 rst_n pulsed mid-word with 2 words queued -> m_tvalid=0 immediately, no stale beats after release.
